forward_cell_link_arb: RTL and testbench

Parametrised successor to the cell-link forwarder. It merges NUM_INPUTS AXI-Stream packet sources through a built-in round-robin packet arbiter, with no external mux IP. It forwards each recognised packet (per-protocol magic, per-cell duplicate suppression) to the outgoing Aurora cell link. Truncated packets (watchdog expiry, FA strobe mid-packet) are closed with an explicit invalid-marked terminator word.

---
 rtl/forward_cell_link_arb_pkg.sv | 18 +
 rtl/forward_cell_link_arb_if.sv | 24 ++
 rtl/forward_cell_link_arb_rr_packet_arbiter.sv | 33 +++
 rtl/forward_cell_link_arb.sv | 197 +++++++++++++++++++
 tb/tb_forward_cell_link_arb.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_cell_link_arb_pkg.sv
// Shared constants for the cell-link forwarder: FSM encodings, protocol magics, header layout.
package forward_cell_link_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] FORWARD   = 2'd1;
  localparam logic [1:0] DISCARD   = 2'd2;
  localparam logic [1:0] TERMINATE = 2'd3;

  localparam logic [15:0] FOFB_MAGIC = 16'hA5BE;
  localparam logic [15:0] FMPS_MAGIC = 16'hB6CF;

  localparam logic [31:0] TERMINATOR_WORD = 32'h4000_0000;

  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_CELL_LSB  = 10;
  localparam int CRC_MARK_BIT  = 30;

endpackage

// File: rtl/forward_cell_link_arb_if.sv
// Bundles the NUM_INPUTS AXI-Stream sources and the outgoing cell-link stream.
interface forward_cell_link_arb_if #(
  parameter int NUM_INPUTS = 3
);
  logic [NUM_INPUTS-1:0]    rxTVALID;
  logic [NUM_INPUTS-1:0]    rxTLAST;
  logic [NUM_INPUTS-1:0]    rxTREADY;
  logic [32*NUM_INPUTS-1:0] rxTDATA;
  logic [NUM_INPUTS-1:0]    rxCRCvalid;
  logic [NUM_INPUTS-1:0]    rxCRCpass;
  logic                     cellLinkTxTVALID;
  logic                     cellLinkTxTLAST;
  logic [31:0]              cellLinkTxTDATA;

  modport master (
    output rxTVALID, rxTLAST, rxTDATA, rxCRCvalid, rxCRCpass,
    input  rxTREADY, cellLinkTxTVALID, cellLinkTxTLAST, cellLinkTxTDATA
  );

  modport slave (
    input  rxTVALID, rxTLAST, rxTDATA, rxCRCvalid, rxCRCpass,
    output rxTREADY, cellLinkTxTVALID, cellLinkTxTLAST, cellLinkTxTDATA
  );
endinterface

// File: rtl/forward_cell_link_arb_rr_packet_arbiter.sv
// Round-robin pick: first requester after i_ptr (wrapping), one-hot grant plus index.
// Purely combinational, zero latency; the pointer register is owned by the caller.
module rr_packet_arbiter #(
  parameter int NUM_INPUTS = 3,
  parameter int PTR_W      = 2
) (
  input  logic [NUM_INPUTS-1:0] i_req,
  input  logic [PTR_W-1:0]      i_ptr,
  output logic [NUM_INPUTS-1:0] o_grant,
  output logic [PTR_W-1:0]      o_grant_idx,
  output logic                  o_grant_vld
);

  int w_idx;

  // Walk from the farthest candidate back to ptr+1 so the nearest requester is assigned last.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    w_idx       = 0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      w_idx = (int'(i_ptr) + k) % NUM_INPUTS;
      if (i_req[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = PTR_W'(w_idx);
        o_grant_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_cell_link_arb.sv
// Merges NUM_INPUTS packet streams onto the Aurora cell link with duplicate suppression and truncation.
// Accept-to-output latency 1 cycle, no output backpressure; FORWARD_CELL_LINK_STATS_EN adds counters.
module forward_cell_link_arb
  import forward_cell_link_pkg::*;
#(
  parameter int                            NUM_INPUTS      = 3,
  parameter int                            NUM_PROTOCOLS   = 2,
  parameter logic [16*NUM_PROTOCOLS-1:0]   PROTOCOL_MAGICS = {FMPS_MAGIC, FOFB_MAGIC},
  parameter int                            MAX_CELLS       = 32,
  parameter int                            WATCHDOG_WIDTH  = 7,
  parameter logic [NUM_INPUTS-1:0]         CRC_CHECK_MASK  = 'b001
) (
  input  logic                    auroraUserClk,
  input  logic                    auroraUserResetN,
  input  logic                    auroraFAstrobe,
  forward_cell_link_arb_if.slave  link
`ifdef FORWARD_CELL_LINK_STATS_EN
  ,
  output logic [15:0]             forwardedCount,
  output logic [15:0]             duplicateCount,
  output logic [15:0]             truncatedCount
`endif
);

  localparam int CELL_INDEX_WIDTH = $clog2(MAX_CELLS);
  localparam int NUM_CELLS        = 1 << CELL_INDEX_WIDTH;
  localparam int PTR_W            = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PROTO_W          = (NUM_PROTOCOLS > 1) ? $clog2(NUM_PROTOCOLS) : 1;

  logic [1:0]                             r_state, w_state_nxt;
  logic [PTR_W-1:0]                       r_ptr, w_sel, w_arb_idx;
  logic [NUM_INPUTS-1:0]                  w_arb_grant, w_grant_oh, w_rdy;
  logic                                   w_arb_vld, w_idle;
  logic [NUM_PROTOCOLS-1:0][NUM_CELLS-1:0] r_bitmap, w_bitmap_nxt;
  logic [WATCHDOG_WIDTH-1:0]              r_wdog;
  logic                                   r_tx_vld, r_tx_last;
  logic [31:0]                            r_tx_dat;
  logic [31:0]                            w_sel_dat;
  logic                                   w_sel_last, w_accept, w_crc_bad;
  logic [15:0]                            w_magic;
  logic [CELL_INDEX_WIDTH-1:0]            w_cell;
  logic [PROTO_W-1:0]                     w_proto;
  logic                                   w_hit, w_dup, w_fwd_hdr;

  rr_packet_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .PTR_W      (PTR_W)
  ) u_arb (
    .i_req       (link.rxTVALID),
    .i_ptr       (r_ptr),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_arb_idx),
    .o_grant_vld (w_arb_vld)
  );

  assign w_idle     = (r_state == IDLE);
  assign w_sel      = w_idle ? w_arb_idx : r_ptr;
  assign w_sel_dat  = link.rxTDATA[32*w_sel +: 32];
  assign w_sel_last = link.rxTLAST[w_sel];
  assign w_grant_oh = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << r_ptr;
  assign w_accept   = |(w_rdy & link.rxTVALID);
  assign w_magic    = w_sel_dat[HDR_MAGIC_LSB +: 16];
  assign w_cell     = w_sel_dat[HDR_CELL_LSB +: CELL_INDEX_WIDTH];
  assign w_crc_bad  = CRC_CHECK_MASK[r_ptr] & w_sel_last &
                      ~(link.rxCRCvalid[r_ptr] & link.rxCRCpass[r_ptr]);

  always_comb begin
    w_hit   = 1'b0;
    w_proto = '0;
    for (int p = NUM_PROTOCOLS-1; p >= 0; p--) begin
      if (w_magic == PROTOCOL_MAGICS[16*p +: 16]) begin
        w_hit   = 1'b1;
        w_proto = PROTO_W'(p);
      end
    end
  end

  // A strobe-cycle header sees the already-cleared bitmap.
  assign w_dup     = r_bitmap[w_proto][w_cell] & ~auroraFAstrobe;
  assign w_fwd_hdr = w_idle & w_arb_vld & w_hit & ~w_dup & ~w_sel_last;

  always_comb begin
    w_bitmap_nxt = auroraFAstrobe ? '0 : r_bitmap;
    if (w_fwd_hdr) begin
      w_bitmap_nxt[w_proto][w_cell] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = '0;
    case (r_state)
      IDLE: begin
        w_rdy = w_arb_grant;
        if (w_fwd_hdr) begin
          w_state_nxt = FORWARD;
        end else if (w_arb_vld && !w_sel_last) begin
          w_state_nxt = DISCARD;
        end
      end
      FORWARD: begin
        if (auroraFAstrobe) begin
          w_state_nxt = TERMINATE;
        end else begin
          w_rdy = w_grant_oh;
          if (w_accept && w_sel_last) begin
            w_state_nxt = IDLE;
          end else if (r_wdog == '0) begin
            w_state_nxt = TERMINATE;
          end
        end
      end
      DISCARD: begin
        w_rdy = w_grant_oh;
        if (w_accept && w_sel_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        // TERMINATE is only reached before the granted TLAST was taken, so the tail must be drained.
        w_state_nxt = DISCARD;
      end
    endcase
  end

  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_bitmap  <= '0;
      r_wdog    <= '0;
      r_tx_vld  <= 1'b0;
      r_tx_last <= 1'b0;
      r_tx_dat  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitmap <= w_bitmap_nxt;
      if (w_idle && w_arb_vld) begin
        r_ptr <= w_arb_idx;
      end
      if (w_fwd_hdr) begin
        r_wdog <= '1;
      end else if (r_state == FORWARD) begin
        r_wdog <= r_wdog - 1'b1;
      end
      r_tx_vld  <= 1'b0;
      r_tx_last <= 1'b0;
      r_tx_dat  <= '0;
      if (w_fwd_hdr) begin
        r_tx_vld <= 1'b1;
        r_tx_dat <= w_sel_dat;
      end else if (r_state == FORWARD && w_accept) begin
        r_tx_vld  <= 1'b1;
        r_tx_last <= w_sel_last;
        r_tx_dat  <= w_sel_dat | (32'(w_crc_bad) << CRC_MARK_BIT);
      end else if (r_state == TERMINATE) begin
        r_tx_vld  <= 1'b1;
        r_tx_last <= 1'b1;
        r_tx_dat  <= TERMINATOR_WORD;
      end
    end
  end

  assign link.rxTREADY         = w_rdy;
  assign link.cellLinkTxTVALID = r_tx_vld;
  assign link.cellLinkTxTLAST  = r_tx_last;
  assign link.cellLinkTxTDATA  = r_tx_dat;

`ifdef FORWARD_CELL_LINK_STATS_EN
  logic [15:0] r_fwd_cnt, r_dup_cnt, r_trunc_cnt;
  logic        w_dup_evt, w_trunc_evt;

  assign w_dup_evt   = w_idle & w_arb_vld & (~w_hit | w_dup);
  assign w_trunc_evt = (r_state == FORWARD) & (w_state_nxt == TERMINATE);

  always_ff @(posedge auroraUserClk or negedge auroraUserResetN) begin
    if (!auroraUserResetN) begin
      r_fwd_cnt   <= '0;
      r_dup_cnt   <= '0;
      r_trunc_cnt <= '0;
    end else if (auroraFAstrobe) begin
      r_fwd_cnt   <= '0;
      r_dup_cnt   <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_fwd_hdr && r_fwd_cnt != 16'hFFFF)     r_fwd_cnt   <= r_fwd_cnt + 16'd1;
      if (w_dup_evt && r_dup_cnt != 16'hFFFF)     r_dup_cnt   <= r_dup_cnt + 16'd1;
      if (w_trunc_evt && r_trunc_cnt != 16'hFFFF) r_trunc_cnt <= r_trunc_cnt + 16'd1;
    end
  end

  assign forwardedCount = r_fwd_cnt;
  assign duplicateCount = r_dup_cnt;
  assign truncatedCount = r_trunc_cnt;
`endif

endmodule

// File: tb/tb_forward_cell_link_arb.sv
// Directed bench: per-input source queues feed the DUT, expected output words wait in a scoreboard.
`timescale 1ns/1ps
module tb_forward_cell_link_arb;
  import forward_cell_link_pkg::*;

  localparam int NI = 3;

  typedef struct packed {
    logic        last;
    logic        crcv;
    logic        crcp;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic fa;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c0;

  beat_t src_q [NI][$];
  exp_t  sb[$];

  forward_cell_link_arb_if #(.NUM_INPUTS(NI)) link ();

`ifdef FORWARD_CELL_LINK_STATS_EN
  logic [15:0] fwd_cnt, dup_cnt, trunc_cnt;
`endif

  forward_cell_link_arb #(.NUM_INPUTS(NI)) dut (
    .auroraUserClk    (clk),
    .auroraUserResetN (rst_n),
    .auroraFAstrobe   (fa),
    .link             (link)
`ifdef FORWARD_CELL_LINK_STATS_EN
    ,
    .forwardedCount   (fwd_cnt),
    .duplicateCount   (dup_cnt),
    .truncatedCount   (trunc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [15:0] m, input int idx);
    return {m, 16'h0} | (32'(idx) << 10);
  endfunction

  function automatic logic [31:0] body_word(input int src, input int idx, input int k);
    return {8'h10 + 8'(src), 8'(idx), 16'(k)};
  endfunction

  function automatic bit busy();
    bit b = (sb.size() != 0);
    for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic push_beat(input int src, input logic [31:0] d, input logic last, input logic crcp);
    beat_t b;
    b.last = last; b.crcv = 1'b1; b.crcp = crcp; b.dat = d;
    src_q[src].push_back(b);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic last, input int c);
    exp_t e;
    e.dat = d; e.last = last; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push_pkt(input int src, input logic [15:0] magic, input int idx, input int n,
                          input bit fwd, input int cyc0);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? mk_hdr(magic, idx) : body_word(src, idx, k);
      push_beat(src, w, k == n-1, 1'b1);
      if (fwd) push_exp(w, k == n-1, (cyc0 < 0) ? -1 : cyc0 + k);
    end
  endtask

  task automatic drive();
    logic [NI-1:0]    v, l, cv, cp;
    logic [32*NI-1:0] d;
    v = '0; l = '0; cv = '0; cp = '0; d = '0;
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() != 0) begin
        v[i] = 1'b1;
        l[i] = src_q[i][0].last;
        cv[i] = src_q[i][0].crcv;
        cp[i] = src_q[i][0].crcp;
        d[32*i +: 32] = src_q[i][0].dat;
      end
    end
    link.rxTVALID = v; link.rxTLAST = l; link.rxCRCvalid = cv;
    link.rxCRCpass = cp; link.rxTDATA = d;
  endtask

  // Entered and left at posedge+1: drive, sample handshake, clock, then score the output register.
  task automatic cycle();
    logic [NI-1:0] acc;
    exp_t e;
    drive();
    #3;
    acc = link.rxTREADY & link.rxTVALID;
    chk("rdy_onehot", {31'b0, ($countones(link.rxTREADY) <= 1)}, 32'd1);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) if (acc[i]) void'(src_q[i].pop_front());
    #1;
    fa = 1'b0;
    if (link.cellLinkTxTVALID) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", link.cellLinkTxTDATA, 32'hFFFF_FFFF ^ link.cellLinkTxTDATA);
      end else begin
        e = sb.pop_front();
        chk("out_dat", link.cellLinkTxTDATA, e.dat);
        chk("out_last", {31'b0, link.cellLinkTxTLAST}, {31'b0, e.last});
        if (e.cyc >= 0) chk("out_cyc", cyc, e.cyc);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_done", {31'b0, busy()}, 32'd0);
    run(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    fa    = 1'b0;
    drive();
    #1;
    chk("rst_vld",  {31'b0, link.cellLinkTxTVALID}, 32'd0);
    chk("rst_last", {31'b0, link.cellLinkTxTLAST}, 32'd0);
    chk("rst_dat",  link.cellLinkTxTDATA, 32'd0);
    chk("rst_rdy",  {29'b0, link.rxTREADY}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain 4-word FOFB packet, output one cycle after each accept.
    push_pkt(0, FOFB_MAGIC, 3, 4, 1'b1, cyc + 1);
    wait_drain(50);

    // Same cell again in the same interval is suppressed; after a strobe it passes.
    push_pkt(1, FOFB_MAGIC, 3, 4, 1'b0, -1);
    wait_drain(50);
    fa = 1'b1;
    run(1);
    push_pkt(1, FOFB_MAGIC, 3, 4, 1'b1, -1);
    wait_drain(50);

    // Single-word header is dropped without leaving IDLE and without marking the cell.
    push_pkt(2, FMPS_MAGIC, 11, 1, 1'b0, -1);
    push_pkt(2, FMPS_MAGIC, 11, 3, 1'b1, cyc + 2);
    wait_drain(50);

    // Asynchronous reset mid-packet clears the output immediately.
    push_pkt(0, FOFB_MAGIC, 20, 5, 1'b0, -1);
    push_exp(mk_hdr(FOFB_MAGIC, 20), 1'b0, -1);
    push_exp(body_word(0, 20, 1), 1'b0, -1);
    run(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_vld",  {31'b0, link.cellLinkTxTVALID}, 32'd0);
    chk("arst_last", {31'b0, link.cellLinkTxTLAST}, 32'd0);
    chk("arst_dat",  link.cellLinkTxTDATA, 32'd0);
    for (int i = 0; i < NI; i++) src_q[i].delete();
    drive();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_sb", 32'(sb.size()), 32'd0);

    // Three simultaneous requesters from pointer 0 are served 1, 2, 0.
    push_pkt(1, FOFB_MAGIC, 1, 3, 1'b1, -1);
    push_pkt(2, FMPS_MAGIC, 2, 3, 1'b1, -1);
    push_pkt(0, FOFB_MAGIC, 4, 3, 1'b1, -1);
    wait_drain(60);

    // CRC failure marks bit 30 only on inputs enabled in the mask.
    push_beat(0, mk_hdr(FOFB_MAGIC, 12), 1'b0, 1'b1);
    push_beat(0, body_word(0, 12, 1), 1'b0, 1'b1);
    push_beat(0, 32'h0000_0005, 1'b1, 1'b0);
    push_exp(mk_hdr(FOFB_MAGIC, 12), 1'b0, -1);
    push_exp(body_word(0, 12, 1), 1'b0, -1);
    push_exp(32'h4000_0005, 1'b1, -1);
    wait_drain(50);
    push_beat(1, mk_hdr(FOFB_MAGIC, 13), 1'b0, 1'b1);
    push_beat(1, body_word(1, 13, 1), 1'b0, 1'b1);
    push_beat(1, 32'h0000_0005, 1'b1, 1'b0);
    push_exp(mk_hdr(FOFB_MAGIC, 13), 1'b0, -1);
    push_exp(body_word(1, 13, 1), 1'b0, -1);
    push_exp(32'h0000_0005, 1'b1, -1);
    wait_drain(50);

    // Stalled packet: terminator 2^7+1 cycles after the header, late tail discarded.
    push_beat(2, mk_hdr(FMPS_MAGIC, 7), 1'b0, 1'b1);
    c0 = cyc + 1;
    push_exp(mk_hdr(FMPS_MAGIC, 7), 1'b0, c0);
    push_exp(TERMINATOR_WORD, 1'b1, c0 + 129);
    run(140);
    chk("timeout_sb", 32'(sb.size()), 32'd0);
`ifdef FORWARD_CELL_LINK_STATS_EN
    chk("trunc_cnt_1", {16'b0, trunc_cnt}, 32'd1);
`endif
    push_beat(2, body_word(2, 7, 1), 1'b0, 1'b1);
    push_beat(2, body_word(2, 7, 2), 1'b1, 1'b1);
    wait_drain(50);

    // Strobe mid-FORWARD: terminator next cycle, rest dropped, bitmaps cleared.
    push_pkt(0, FOFB_MAGIC, 9, 6, 1'b0, -1);
    push_exp(mk_hdr(FOFB_MAGIC, 9), 1'b0, -1);
    push_exp(body_word(0, 9, 1), 1'b0, -1);
    run(2);
    push_exp(TERMINATOR_WORD, 1'b1, cyc + 2);
    fa = 1'b1;
    run(1);
    wait_drain(50);
`ifdef FORWARD_CELL_LINK_STATS_EN
    chk("trunc_cnt_0", {16'b0, trunc_cnt}, 32'd0);
`endif
    push_pkt(1, FOFB_MAGIC, 9, 3, 1'b1, -1);
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
